// File: rtl/ofdm_symbol_mapper_ctrl.sv
// OFDM symbol mapper controller.
// Walks the bins k = 0..N_FFT-1 of one symbol in IFFT order. Each bin is one of:
//   - a null (DC or upper guard)
//   - a pilot (fixed level)
//   - a data bin, taken from the external combinational modulator
// Bins are emitted through a single output register slot.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge where
// valid and ready are both high. A source never withdraws valid or changes its
// payload while valid is high and ready is low.
//
// dbg_state exposes the FSM state (0=IDLE, 1=MAP, 2=DRAIN).
module ofdm_symbol_mapper_ctrl #(
  parameter int MAX_BIT_ORDER = 6,
  parameter int DATA_W        = 12,
  parameter int N_FFT         = 64,
  parameter int N_ACTIVE      = 52,
  parameter int PILOT_SPACING = 13,
  parameter int PILOT_LEVEL   = 1200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               bit_order,
  input  logic [MAX_BIT_ORDER-1:0] s_bits,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [MAX_BIT_ORDER-1:0] mod_bits,
  input  logic [DATA_W-1:0]        mod_i,
  input  logic [DATA_W-1:0]        mod_q,
  output logic [DATA_W-1:0]        m_i,
  output logic [DATA_W-1:0]        m_q,
  output logic [$clog2(N_FFT)-1:0] m_idx,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic                     cfg_err,
  output logic [1:0]               dbg_state
);

  localparam int KW = $clog2(N_FFT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAP   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [2:0]          order_q, order_d;
  logic [DATA_W-1:0]   m_i_q, m_i_d;
  logic [DATA_W-1:0]   m_q_q, m_q_d;
  logic [KW-1:0]       m_idx_q, m_idx_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic                busy_q, busy_d;
  logic                cfg_err_q, cfg_err_d;

  logic                slot_free;
  logic                is_null;
  logic                is_pilot;
  logic                is_data;
  logic                is_last_k;
  logic                order_ok;
  logic                order_bpsk;
  logic [31:0]         k_ext;

  // Bin classification of the current k, plus output-slot availability.
  always_comb begin
    k_ext      = 32'(k_q);
    is_null    = (k_ext == 32'd0) || (k_ext > 32'(N_ACTIVE));
    is_pilot   = !is_null && (((k_ext - 32'd1) % 32'(PILOT_SPACING)) == 32'd0);
    is_data    = !is_null && !is_pilot;
    is_last_k  = (k_q == KW'(N_FFT - 1));
    slot_free  = !m_valid_q || m_ready;
    order_ok   = (bit_order == 3'd1) || (bit_order == 3'd2);
    order_bpsk = (order_q == 3'd1);
  end

  // Modulator drive: BPSK repeats bit 0 onto bit 1 so the modulator sees a
  // symmetric constellation point.
  always_comb begin
    mod_bits = s_bits;
    if (order_bpsk) begin
      mod_bits[1] = s_bits[0];
    end
  end

  // Next-state, bin loading and status logic.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    order_d   = order_q;
    m_i_d     = m_i_q;
    m_q_d     = m_q_q;
    m_idx_d   = m_idx_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    cfg_err_d = 1'b0;

    // A free slot empties unless a new bin is loaded below.
    if (slot_free) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (order_ok) begin
            order_d = bit_order;
            k_d     = '0;
            busy_d  = 1'b1;
            state_d = S_MAP;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      S_MAP: begin
        // Null/pilot bins load whenever the slot is free. Data bins also need
        // an upstream bit group.
        if (slot_free && (!is_data || s_valid)) begin
          m_valid_d = 1'b1;
          m_idx_d   = k_q;
          m_last_d  = is_last_k;
          if (is_null) begin
            m_i_d = '0;
            m_q_d = '0;
          end else if (is_pilot) begin
            m_i_d = DATA_W'(PILOT_LEVEL);
            m_q_d = '0;
          end else begin
            m_i_d = mod_i;
            m_q_d = order_bpsk ? '0 : mod_q;
          end
          if (is_last_k) begin
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      S_DRAIN: begin
        // The slot holds the m_last bin. Finish once it is accepted.
        if (m_ready) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      order_q   <= '0;
      m_i_q     <= '0;
      m_q_q     <= '0;
      m_idx_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      order_q   <= order_d;
      m_i_q     <= m_i_d;
      m_q_q     <= m_q_d;
      m_idx_q   <= m_idx_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign s_ready   = (state_q == S_MAP) && is_data && slot_free;
  assign m_i       = m_i_q;
  assign m_q       = m_q_q;
  assign m_idx     = m_idx_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ofdm_symbol_mapper_ctrl.sv
// Testbench for ofdm_symbol_mapper_ctrl.
// Contains a toy combinational modulator and builds each expected symbol from
// the bin rules.
module tb_ofdm_symbol_mapper_ctrl;

  localparam int MBO = 6;
  localparam int DW  = 12;
  localparam int NF  = 64;
  localparam int NA  = 52;
  localparam int PS  = 13;
  localparam int PL  = 1200;
  localparam int KW  = 6;
  localparam int W   = 2 * DW + KW + 1;

  localparam logic [DW-1:0] POS = DW'(PL);
  localparam logic [DW-1:0] NEG = DW'(-PL);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     bit_order = 3'd0;
  logic [MBO-1:0] s_bits = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [MBO-1:0] mod_bits;
  logic [DW-1:0]  mod_i, mod_q;
  logic [DW-1:0]  m_i, m_q;
  logic [KW-1:0]  m_idx;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic           m_last;
  logic           busy;
  logic           cfg_err;
  logic [1:0]     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ofdm_symbol_mapper_ctrl #(
    .MAX_BIT_ORDER(MBO), .DATA_W(DW), .N_FFT(NF), .N_ACTIVE(NA),
    .PILOT_SPACING(PS), .PILOT_LEVEL(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_order(bit_order),
    .s_bits(s_bits), .s_valid(s_valid), .s_ready(s_ready),
    .mod_bits(mod_bits), .mod_i(mod_i), .mod_q(mod_q),
    .m_i(m_i), .m_q(m_q), .m_idx(m_idx), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // Toy modulator: bit0 selects the sign of I, bit1 selects the sign of Q.
  always_comb begin
    mod_i = mod_bits[0] ? POS : NEG;
    mod_q = mod_bits[1] ? POS : NEG;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [MBO-1:0] exp_mod(input int order, input logic [MBO-1:0] b);
    logic [MBO-1:0] r;
    r = b;
    if (order == 1) r[1] = b[0];
    return r;
  endfunction

  function automatic bit bin_is_data(input int k);
    return !(k == 0 || k > NA) && ((k - 1) % PS != 0);
  endfunction

  function automatic logic [W-1:0] exp_bin(input int k, input int order, input logic [MBO-1:0] b);
    logic [DW-1:0]  i, q;
    logic [MBO-1:0] mb;
    if (k == 0 || k > NA) begin
      i = '0; q = '0;
    end else if ((k - 1) % PS == 0) begin
      i = POS; q = '0;
    end else begin
      mb = exp_mod(order, b);
      i  = mb[0] ? POS : NEG;
      q  = (order == 1) ? '0 : (mb[1] ? POS : NEG);
    end
    return {i, q, KW'(k), (k == NF - 1)};
  endfunction

  // ---------------- driver + scoreboard ----------------
  // Call between edges, just after a negedge. Pulses start for the next edge,
  // then drives both handshakes cycle by cycle and scores every output
  // transfer. Returns once busy is seen low again. If abort_idx >= 0, returns
  // right after the bin with that index is accepted.
  task automatic run_symbol(input int order, input int mode, input int rdy_pct,
                            input int vld_pct, input bit inject, input int abort_idx);
    logic [MBO-1:0] grp[$];
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   word, held;
    logic [MBO-1:0] g;
    bit             hold;
    bit             aborted;
    int             gi, nbins, hs, busy_cyc, cyc, ndata;

    hold = 0; aborted = 0; held = '0;
    gi = 0; nbins = 0; hs = 0; busy_cyc = 0; cyc = 0; ndata = 0;

    for (int k = 0; k < NF; k++) begin
      g = '0;
      if (bin_is_data(k)) begin
        case (mode)
          0:       g = MBO'(ndata % 4);
          1:       g = MBO'(ndata % 2);
          default: g = MBO'($urandom);
        endcase
        grp.push_back(g);
        ndata++;
      end
      exp_q.push_back(exp_bin(k, order, g));
    end

    start = 1'b1;
    bit_order = 3'(order);
    while (1) begin
      @(negedge clk);
      cyc++;
      start     = inject && (cyc == 20);
      bit_order = 3'($urandom_range(0, 7));
      m_ready   = ($urandom_range(0, 99) < rdy_pct);
      if (gi < grp.size()) begin
        s_valid = ($urandom_range(0, 99) < vld_pct);
        s_bits  = grp[gi];
      end else begin
        s_valid = 1'($urandom_range(0, 1));
        s_bits  = MBO'($urandom);
      end
      #1;
      word = {m_i, m_q, m_idx, m_last};
      if (busy) busy_cyc++;
      chk("cfg_err_in_symbol", cfg_err, 0);
      if (!busy) chk("s_ready_when_idle", s_ready, 0);
      if (hold) chk("held_bin_stable", {m_valid, word}, {1'b1, held});
      if (s_valid && s_ready) begin
        if (gi < grp.size()) chk("mod_bits", mod_bits, exp_mod(order, grp[gi]));
        gi++;
        hs++;
      end
      if (m_valid && m_ready) begin
        nbins++;
        if (exp_q.size() == 0) chk("extra_bin", 1, 0);
        else chk("bin", word, exp_q.pop_front());
        if (abort_idx >= 0 && int'(m_idx) == abort_idx) begin
          aborted = 1;
          break;
        end
      end
      hold = m_valid && !m_ready;
      held = word;
      if (!busy) break;
      if (cyc > 4000) begin
        chk("symbol_timeout", 1, 0);
        break;
      end
    end

    if (!aborted) begin
      chk("bin_count", nbins, NF);
      chk("s_handshakes", hs, ndata);
      chk("bins_missing", exp_q.size(), 0);
      chk("idle_after_symbol", {m_valid, dbg_state}, 3'b000);
      if (rdy_pct == 100 && vld_pct == 100) chk("busy_cycles", busy_cyc, NF + 1);
    end
  endtask

  task automatic bad_start(input logic [2:0] ord);
    @(negedge clk);
    start = 1'b1; bit_order = ord;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_no_out", m_valid, 0);
    @(negedge clk);
    #1;
    chk("cfg_err_clears", cfg_err, 0);
    chk("cfg_err_state", dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_word", {m_i, m_q, m_idx, m_last}, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // QPSK then BPSK with both sides always ready. The second QPSK symbol
    // also checks the 0..3 bit-cycling pattern again, back to back.
    run_symbol(2, 0, 100, 100, 0, -1);
    run_symbol(1, 1, 100, 100, 0, -1);
    run_symbol(2, 0, 100, 100, 0, -1);

    // Unsupported orders.
    bad_start(3'd3);
    bad_start(3'd0);

    // Start during MAP is ignored.
    run_symbol(2, 2, 100, 100, 1, -1);

    // Random backpressure and upstream gaps.
    for (int n = 0; n < 6; n++) begin
      run_symbol((n % 2) + 1, 2, 50, 60, n[0], -1);
    end

    // Reset mid-symbol at idx 30, then a fresh symbol.
    run_symbol(2, 2, 100, 100, 0, 30);
    @(negedge clk);
    rst_n = 1'b0; m_ready = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_state", dbg_state, 0);
    run_symbol(2, 2, 70, 80, 0, -1);
    run_symbol(1, 2, 100, 100, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
